// File: rtl/fifo_pkg.sv
// Shared read-mode constants, flag bundle and helpers for the single-clock FIFO family.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Registered status bundle; kept as one struct so it can be probed as a unit.
    typedef struct packed {
        logic wr_full;
        logic almost_full;
        logic rd_empty;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_flags_t;

    localparam fifo_flags_t FLAGS_RESET = '{
        wr_full:      1'b0,
        almost_full:  1'b0,
        rd_empty:     1'b1,
        almost_empty: 1'b1,
        overflow:     1'b0,
        underflow:    1'b0
    };

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port RAM: one write port and one registered read port with
// one cycle of read latency.
module sync_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    end

    // Only the read register is reset; the array keeps stale contents.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        rd_data_q <= '0;
        else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo_wl.sv
// Single-clock FIFO with water level, programmable almost-full/almost-empty
// thresholds, standard or FWFT read mode and sticky overflow/underflow flags.
module sync_fifo_wl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH_WIDTH = 13,
    parameter int FWFT        = FIFO_MODE_STD
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    output logic                   wr_full,
    output logic                   almost_full,
    input  logic                   rd_en,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   rd_valid,
    output logic                   rd_empty,
    output logic                   almost_empty,
    output logic [DEPTH_WIDTH:0]   water_level,
    input  logic [DEPTH_WIDTH:0]   af_thresh,
    input  logic [DEPTH_WIDTH:0]   ae_thresh,
    output logic                   overflow,
    output logic                   underflow,
    input  logic                   clr_err
);

    localparam int LW    = DEPTH_WIDTH + 1;
    localparam int DEPTH = 1 << DEPTH_WIDTH;
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

    // Handshake: a write is taken at a rising edge when wr_en=1 and wr_full=0;
    // a read (standard) or pop (FWFT) is taken when rd_en=1 and rd_empty=0.
    // Both use the registered flags seen before that edge; a request against a
    // full/empty FIFO is dropped and recorded in overflow/underflow.

    logic [LW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    fifo_flags_t   flags_q, flags_d;
    logic          out_valid_q, out_valid_d;
    logic          rd_valid_q, rd_valid_d;
    logic          wr_acc, rd_acc, ram_rd, ram_has_word;

    always_comb begin
        wr_acc       = wr_en & ~flags_q.wr_full;
        rd_acc       = rd_en & ~flags_q.rd_empty;
        ram_has_word = (wr_ptr_q != rd_ptr_q);
        level_d      = level_q + LW'(wr_acc) - LW'(rd_acc);

        if (FWFT == FIFO_MODE_FWFT) begin
            // The RAM read register doubles as the output register: refill it
            // whenever it is empty or its word is being popped.
            ram_rd      = ram_has_word & (~out_valid_q | rd_acc);
            out_valid_d = ram_rd | (out_valid_q & ~rd_acc);
            rd_valid_d  = 1'b0;
        end else begin
            ram_rd      = rd_acc;
            out_valid_d = 1'b0;
            rd_valid_d  = rd_acc;
        end

        wr_ptr_d = wr_ptr_q + LW'(wr_acc);
        rd_ptr_d = rd_ptr_q + LW'(ram_rd);

        flags_d.wr_full      = (level_d == LEVEL_FULL);
        flags_d.almost_full  = (level_d >= af_thresh);
        flags_d.rd_empty     = (FWFT == FIFO_MODE_FWFT) ? ~out_valid_d : (level_d == '0);
        flags_d.almost_empty = (level_d <= ae_thresh);
        // A failed attempt in the same cycle as clr_err keeps the flag set.
        flags_d.overflow     = (wr_en & flags_q.wr_full)  | (flags_q.overflow  & ~clr_err);
        flags_d.underflow    = (rd_en & flags_q.rd_empty) | (flags_q.underflow & ~clr_err);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            flags_q     <= FLAGS_RESET;
            out_valid_q <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (DEPTH_WIDTH)
    ) u_ram (
        .clk_i     (clk),
        .rst_i     (rst),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wr_ptr_q[DEPTH_WIDTH-1:0]),
        .wr_data_i (wr_data),
        .rd_en_i   (ram_rd),
        .rd_addr_i (rd_ptr_q[DEPTH_WIDTH-1:0]),
        .rd_data_o (rd_data)
    );

    assign wr_full      = flags_q.wr_full;
    assign almost_full  = flags_q.almost_full;
    assign rd_empty     = flags_q.rd_empty;
    assign almost_empty = flags_q.almost_empty;
    assign overflow     = flags_q.overflow;
    assign underflow    = flags_q.underflow;
    assign water_level  = level_q;
    assign rd_valid     = (FWFT == FIFO_MODE_FWFT) ? ~flags_q.rd_empty : rd_valid_q;

endmodule

// File: tb/tb_sync_fifo_wl.sv
// Bench for sync_fifo_wl: a standard-mode and an FWFT instance share one input
// stream and are each compared every cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_sync_fifo_wl;
    import fifo_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = clog2(DEPTH);
    localparam int LW    = AW + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          wr_en   = 1'b0;
    logic          rd_en   = 1'b0;
    logic          clr_err = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [LW-1:0] af_thresh = LW'(12);
    logic [LW-1:0] ae_thresh = LW'(3);

    logic          std_wr_full, std_af, std_rd_valid, std_rd_empty, std_ae, std_ovf, std_unf;
    logic [DW-1:0] std_rd_data;
    logic [LW-1:0] std_level;
    logic          ff_wr_full, ff_af, ff_rd_valid, ff_rd_empty, ff_ae, ff_ovf, ff_unf;
    logic [DW-1:0] ff_rd_data;
    logic [LW-1:0] ff_level;

    sync_fifo_wl #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .FWFT(FIFO_MODE_STD)) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_full(std_wr_full),
        .almost_full(std_af), .rd_en(rd_en), .rd_data(std_rd_data), .rd_valid(std_rd_valid),
        .rd_empty(std_rd_empty), .almost_empty(std_ae), .water_level(std_level),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .overflow(std_ovf),
        .underflow(std_unf), .clr_err(clr_err)
    );

    sync_fifo_wl #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .FWFT(FIFO_MODE_FWFT)) u_ff (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_full(ff_wr_full),
        .almost_full(ff_af), .rd_en(rd_en), .rd_data(ff_rd_data), .rd_valid(ff_rd_valid),
        .rd_empty(ff_rd_empty), .almost_empty(ff_ae), .water_level(ff_level),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .overflow(ff_ovf),
        .underflow(ff_unf), .clr_err(clr_err)
    );

    // ---------------- scoreboard / reference model ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] exp_q[$];   // standard mode: words held, head first
    logic [DW-1:0] exp_fq[$];  // FWFT: words still behind the output register
    bit ms_full, ms_af, ms_empty, ms_ae, ms_valid, ms_ovf, ms_unf;
    logic [DW-1:0] ms_data;
    int ms_lvl;
    bit mf_full, mf_af, mf_ae, mf_ovf, mf_unf, mf_out_v;
    logic [DW-1:0] mf_out_d;
    int mf_lvl;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_fq.delete();
        ms_full = 0; ms_af = 0; ms_empty = 1; ms_ae = 1; ms_valid = 0; ms_ovf = 0; ms_unf = 0;
        ms_data = '0; ms_lvl = 0;
        mf_full = 0; mf_af = 0; mf_ae = 1; mf_ovf = 0; mf_unf = 0; mf_out_v = 0;
        mf_out_d = '0; mf_lvl = 0;
    endtask

    // Advance both models by one rising edge using the inputs currently driven.
    task automatic model_edge();
        bit wa, ra;
        wa = wr_en && !ms_full;
        ra = rd_en && !ms_empty;
        ms_ovf   = (wr_en && ms_full)  || (ms_ovf && !clr_err);
        ms_unf   = (rd_en && ms_empty) || (ms_unf && !clr_err);
        ms_valid = ra;
        if (ra) ms_data = exp_q.pop_front();
        if (wa) exp_q.push_back(wr_data);
        ms_lvl   = exp_q.size();
        ms_full  = (ms_lvl == DEPTH);
        ms_empty = (ms_lvl == 0);
        ms_af    = (ms_lvl >= int'(af_thresh));
        ms_ae    = (ms_lvl <= int'(ae_thresh));

        wa = wr_en && !mf_full;
        ra = rd_en && mf_out_v;
        mf_ovf = (wr_en && mf_full)   || (mf_ovf && !clr_err);
        mf_unf = (rd_en && !mf_out_v) || (mf_unf && !clr_err);
        if (exp_fq.size() > 0 && (!mf_out_v || ra)) begin
            mf_out_d = exp_fq.pop_front();
            mf_out_v = 1;
        end else if (ra) begin
            mf_out_v = 0;
        end
        if (wa) exp_fq.push_back(wr_data);
        mf_lvl  = exp_fq.size() + int'(mf_out_v);
        mf_full = (mf_lvl == DEPTH);
        mf_af   = (mf_lvl >= int'(af_thresh));
        mf_ae   = (mf_lvl <= int'(ae_thresh));
    endtask

    task automatic compare_outputs();
        check_eq("std_level", 32'(std_level), 32'(ms_lvl));
        check_eq("std_flags",
                 32'({std_wr_full, std_af, std_rd_empty, std_ae, std_rd_valid, std_ovf, std_unf}),
                 32'({ms_full, ms_af, ms_empty, ms_ae, ms_valid, ms_ovf, ms_unf}));
        check_eq("std_rd_data", 32'(std_rd_data), 32'(ms_data));
        check_eq("ff_level", 32'(ff_level), 32'(mf_lvl));
        check_eq("ff_flags",
                 32'({ff_wr_full, ff_af, ff_rd_empty, ff_ae, ff_rd_valid, ff_ovf, ff_unf}),
                 32'({mf_full, mf_af, !mf_out_v, mf_ae, mf_out_v, mf_ovf, mf_unf}));
        if (mf_out_v) check_eq("ff_rd_data", 32'(ff_rd_data), 32'(mf_out_d));
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle(input logic we, input logic [DW-1:0] wd, input logic re, input logic ce);
        wr_en = we; wr_data = wd; rd_en = re; clr_err = ce;
        model_edge();
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 3 * DEPTH; i++) begin
            if (ms_lvl == 0 && mf_lvl == 0) break;
            cycle(1'b0, '0, 1'b1, 1'b0);
        end
        check_eq("drain_done", 32'(ms_lvl + mf_lvl), 32'd0);
        cycle(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic async_reset_mid_cycle();
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_outputs();
        check_eq("rst_std_rd_data", 32'(std_rd_data), 32'd0);
        check_eq("rst_ff_rd_data", 32'(ff_rd_data), 32'd0);
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        #1 rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_outputs();
        rst = 1'b0;

        // Fill 0xFF down to 0xF0; threshold crossings at 4th and 12th word.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, DW'(8'hFF - i), 1'b0, 1'b0);
            if (i == 2)  check_eq("ae_high_3", 32'(std_ae), 32'd1);
            if (i == 3)  check_eq("ae_low_4", 32'(std_ae), 32'd0);
            if (i == 10) check_eq("af_low_11", 32'(std_af), 32'd0);
            if (i == 11) check_eq("af_high_12", 32'(std_af), 32'd1);
        end
        check_eq("full_after_16", 32'(std_wr_full), 32'd1);
        check_eq("level_16", 32'(std_level), 32'd16);
        cycle(1'b1, 8'h11, 1'b0, 1'b0);
        check_eq("ovf_17th", 32'(std_ovf), 32'd1);
        check_eq("level_still_16", 32'(std_level), 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            check_eq("std_read_valid", 32'(std_rd_valid), 32'd1);
            check_eq("std_read_order", 32'(std_rd_data), 32'(8'hFF - i));
        end
        check_eq("empty_after_16", 32'(std_rd_empty), 32'd1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        check_eq("ovf_cleared", 32'(std_ovf), 32'd0);

        // Underflow on empty, then clear.
        cycle(1'b0, '0, 1'b1, 1'b0);
        check_eq("unf_set", 32'(std_unf), 32'd1);
        check_eq("unf_level0", 32'(std_level), 32'd0);
        check_eq("unf_no_valid", 32'(std_rd_valid), 32'd0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        check_eq("unf_cleared", 32'(std_unf), 32'd0);

        // FWFT single-word latency.
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        check_eq("ff_empty_after_wr", 32'(ff_rd_empty), 32'd1);
        cycle(1'b0, '0, 1'b0, 1'b0);
        check_eq("ff_visible", 32'(ff_rd_empty), 32'd0);
        check_eq("ff_data_a5", 32'(ff_rd_data), 32'hA5);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check_eq("ff_empty_after_pop", 32'(ff_rd_empty), 32'd1);
        drain();

        // Gap-free streaming at constant level.
        push_n(4);
        cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) begin
            cycle(1'b1, DW'($urandom), 1'b1, 1'b0);
            check_eq("stream_ff_valid", 32'(ff_rd_valid), 32'd1);
            check_eq("stream_ff_level", 32'(ff_level), 32'd4);
        end
        drain();

        // Simultaneous write+read at full, then wrap-around traffic.
        push_n(DEPTH);
        cycle(1'b1, 8'h77, 1'b1, 1'b0);
        check_eq("full_wr_rd_level", 32'(std_level), 32'd15);
        check_eq("full_wr_rd_ovf", 32'(std_ovf), 32'd1);
        for (int i = 0; i < 40; i++)
            cycle(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        drain();

        // Randomized phases with varied thresholds and traffic mix.
        for (int ph = 0; ph < 4; ph++) begin
            int pw;
            af_thresh = LW'($urandom_range(0, DEPTH));
            ae_thresh = LW'($urandom_range(0, DEPTH));
            pw = $urandom_range(20, 80);
            for (int c = 0; c < 120; c++)
                cycle(1'($urandom_range(0, 99) < pw), DW'($urandom),
                      1'($urandom_range(0, 99) >= pw), 1'($urandom_range(0, 19) == 0));
        end
        af_thresh = LW'(12);
        ae_thresh = LW'(3);
        drain();

        // Asynchronous reset mid-burst at level 9, then recovery.
        push_n(9);
        check_eq("pre_rst_level9", 32'(std_level), 32'd9);
        wr_en = 1'b1;
        async_reset_mid_cycle();
        cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        check_eq("post_rst_ff_data", 32'(ff_rd_data), 32'h3C);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check_eq("post_rst_std_data", 32'(std_rd_data), 32'h3C);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
